// File: rtl/rx_path_ctrl.sv
// Receive-path enable controller: gates fmac_rxd_en on software enable, link state
// and idle alignment, and drains an open frame before shutting the path down.
module rx_path_ctrl #(
  parameter int IDLE_CNT  = 8,
  parameter int DRAIN_TMO = 2048
) (
  input  logic        xaui_clk,
  input  logic        reset_,
  input  logic        sw_rx_en,
  input  logic        xaui_mode,
  input  logic        linkup,
  input  logic [63:0] data_in,
  input  logic [7:0]  ctrl_in,
  input  logic        clr_cnt,
  output logic        rx_en,
  output logic [2:0]  ctl_state,
  output logic        in_frame,
  output logic        abort_pulse,
  output logic [15:0] abort_cnt
);

  localparam int IW = (IDLE_CNT < 2) ? 1 : $clog2(IDLE_CNT + 1);
  localparam int DW = (DRAIN_TMO < 2) ? 1 : $clog2(DRAIN_TMO);
  localparam logic [IW-1:0] IDLE_LAST = IW'(IDLE_CNT - 1);
  localparam logic [IW-1:0] IDLE_MAX  = IW'(IDLE_CNT);
  localparam logic [DW-1:0] DRAIN_LAST = DW'(DRAIN_TMO - 1);

  typedef enum logic [2:0] {
    ST_DISABLED  = 3'd0,
    ST_WAIT_LINK = 3'd1,
    ST_WAIT_IDLE = 3'd2,
    ST_ACTIVE    = 3'd3,
    ST_DRAIN     = 3'd4
  } state_t;

  function automatic logic f_is_sof0(input logic [63:0] d, input logic [7:0] c);
    return c[0] & (d[7:0] == 8'hFB);
  endfunction

  function automatic logic f_is_sof4(input logic [63:0] d, input logic [7:0] c);
    return c[4] & (d[39:32] == 8'hFB);
  endfunction

  function automatic logic f_is_eof(input logic [63:0] d, input logic [7:0] c);
    logic hit;
    hit = 1'b0;
    for (int n = 0; n < 8; n++) begin
      hit = hit | (c[n] & (d[8*n +: 8] == 8'hFD));
    end
    return hit;
  endfunction

  // Only a full /I/ column (all lanes control 07) counts; 9C ordered sets do not.
  function automatic logic f_is_idle(input logic [63:0] d, input logic [7:0] c);
    return (c == 8'hFF) & (d == {8{8'h07}});
  endfunction

  // SOF in lane 4 wins so an EOF+SOF4 word leaves a new frame open.
  function automatic logic f_frame_next(input logic sof0, input logic sof4,
                                        input logic eof, input logic cur);
    logic nxt;
    if (sof4) begin
      nxt = 1'b1;
    end else if (eof) begin
      nxt = 1'b0;
    end else if (sof0) begin
      nxt = 1'b1;
    end else begin
      nxt = cur;
    end
    return nxt;
  endfunction

  state_t          state_r;
  state_t          state_nxt_s;
  state_t          exit_state_s;
  logic [IW-1:0]   idle_cnt_r;
  logic [IW-1:0]   idle_nxt_s;
  logic [DW-1:0]   drain_cnt_r;
  logic [DW-1:0]   drain_nxt_s;
  logic            rx_en_r;
  logic            in_frame_r;
  logic            in_frame_nxt_s;
  logic            abort_pulse_r;
  logic            abort_s;
  logic [15:0]     abort_cnt_r;
  logic            link_ok_s;
  logic            sof0_s;
  logic            sof4_s;
  logic            eof_s;
  logic            idle_s;

  assign sof0_s         = f_is_sof0(data_in, ctrl_in);
  assign sof4_s         = f_is_sof4(data_in, ctrl_in);
  assign eof_s          = f_is_eof(data_in, ctrl_in);
  assign idle_s         = f_is_idle(data_in, ctrl_in);
  assign in_frame_nxt_s = f_frame_next(sof0_s, sof4_s, eof_s, in_frame_r);
  assign link_ok_s      = linkup | ~xaui_mode;
  assign exit_state_s   = sw_rx_en ? ST_WAIT_LINK : ST_DISABLED;

  // Next-state, counter and abort decode.
  always_comb begin
    state_nxt_s = ST_DISABLED;
    idle_nxt_s  = '0;
    drain_nxt_s = '0;
    abort_s     = 1'b0;
    case (state_r)
      ST_DISABLED: begin
        if (sw_rx_en) begin
          state_nxt_s = ST_WAIT_LINK;
        end else begin
          state_nxt_s = ST_DISABLED;
        end
      end
      ST_WAIT_LINK: begin
        if (!sw_rx_en) begin
          state_nxt_s = ST_DISABLED;
        end else if (link_ok_s) begin
          state_nxt_s = ST_WAIT_IDLE;
        end else begin
          state_nxt_s = ST_WAIT_LINK;
        end
      end
      ST_WAIT_IDLE: begin
        if (!sw_rx_en) begin
          state_nxt_s = ST_DISABLED;
        end else if (!link_ok_s) begin
          state_nxt_s = ST_WAIT_LINK;
        end else if (idle_s) begin
          if (idle_cnt_r == IDLE_LAST) begin
            state_nxt_s = ST_ACTIVE;
          end else begin
            state_nxt_s = ST_WAIT_IDLE;
            idle_nxt_s  = (idle_cnt_r == IDLE_MAX) ? idle_cnt_r : idle_cnt_r + IW'(1);
          end
        end else begin
          state_nxt_s = ST_WAIT_IDLE;
        end
      end
      ST_ACTIVE: begin
        if (!sw_rx_en || !link_ok_s) begin
          if (in_frame_nxt_s) begin
            state_nxt_s = ST_DRAIN;
          end else begin
            state_nxt_s = exit_state_s;
          end
        end else begin
          state_nxt_s = ST_ACTIVE;
        end
      end
      ST_DRAIN: begin
        // EOF closes the frame cleanly even on the timeout cycle or with the link gone.
        if (eof_s) begin
          state_nxt_s = exit_state_s;
        end else if (!link_ok_s || (drain_cnt_r == DRAIN_LAST)) begin
          state_nxt_s = exit_state_s;
          abort_s     = 1'b1;
        end else begin
          state_nxt_s = ST_DRAIN;
          drain_nxt_s = drain_cnt_r + DW'(1);
        end
      end
      default: begin
        state_nxt_s = ST_DISABLED;
      end
    endcase
  end

  // State, counters and registered outputs.
  always_ff @(posedge xaui_clk or negedge reset_) begin
    if (!reset_) begin
      state_r       <= ST_DISABLED;
      idle_cnt_r    <= '0;
      drain_cnt_r   <= '0;
      rx_en_r       <= 1'b0;
      in_frame_r    <= 1'b0;
      abort_pulse_r <= 1'b0;
    end else begin
      state_r       <= state_nxt_s;
      idle_cnt_r    <= idle_nxt_s;
      drain_cnt_r   <= drain_nxt_s;
      rx_en_r       <= (state_nxt_s == ST_ACTIVE) || (state_nxt_s == ST_DRAIN);
      in_frame_r    <= in_frame_nxt_s;
      abort_pulse_r <= abort_s;
    end
  end

  // Saturating abort counter; a clear on the same edge as an abort yields zero.
  always_ff @(posedge xaui_clk or negedge reset_) begin
    if (!reset_) begin
      abort_cnt_r <= 16'h0000;
    end else if (clr_cnt) begin
      abort_cnt_r <= 16'h0000;
    end else if (abort_s && (abort_cnt_r != 16'hFFFF)) begin
      abort_cnt_r <= abort_cnt_r + 16'h0001;
    end else begin
      abort_cnt_r <= abort_cnt_r;
    end
  end

  assign rx_en       = rx_en_r;
  assign ctl_state   = state_r;
  assign in_frame    = in_frame_r;
  assign abort_pulse = abort_pulse_r;
  assign abort_cnt   = abort_cnt_r;

endmodule

// File: tb/tb_rx_path_ctrl.sv
// Directed scoreboard bench for rx_path_ctrl: expected state/output tuples are queued
// per driven cycle and compared one edge later with immediate assertions.
module tb_rx_path_ctrl;

  localparam int IDLE_CNT  = 8;
  localparam int DRAIN_TMO = 16;
  localparam logic [2:0] S_DIS = 3'd0;
  localparam logic [2:0] S_WL  = 3'd1;
  localparam logic [2:0] S_WI  = 3'd2;
  localparam logic [2:0] S_AC  = 3'd3;
  localparam logic [2:0] S_DR  = 3'd4;

  logic        xaui_clk = 1'b0;
  logic        reset_;
  logic        sw_rx_en;
  logic        xaui_mode;
  logic        linkup;
  logic [63:0] data_in;
  logic [7:0]  ctrl_in;
  logic        clr_cnt;
  logic        rx_en;
  logic [2:0]  ctl_state;
  logic        in_frame;
  logic        abort_pulse;
  logic [15:0] abort_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    string       tag;
    logic [2:0]  st;
    logic        rx;
    logic        inf;
    logic        ap;
    logic [15:0] cnt;
  } exp_t;

  exp_t sb_q[$];

  rx_path_ctrl #(.IDLE_CNT(IDLE_CNT), .DRAIN_TMO(DRAIN_TMO)) dut (
    .xaui_clk(xaui_clk), .reset_(reset_), .sw_rx_en(sw_rx_en), .xaui_mode(xaui_mode),
    .linkup(linkup), .data_in(data_in), .ctrl_in(ctrl_in), .clr_cnt(clr_cnt),
    .rx_en(rx_en), .ctl_state(ctl_state), .in_frame(in_frame),
    .abort_pulse(abort_pulse), .abort_cnt(abort_cnt)
  );

  always #5 xaui_clk = ~xaui_clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input exp_t e);
    chk($sformatf("%s.state", e.tag), 16'(ctl_state), 16'(e.st));
    chk($sformatf("%s.rx_en", e.tag), 16'(rx_en), 16'(e.rx));
    chk($sformatf("%s.in_frame", e.tag), 16'(in_frame), 16'(e.inf));
    chk($sformatf("%s.abort_pulse", e.tag), 16'(abort_pulse), 16'(e.ap));
    chk($sformatf("%s.abort_cnt", e.tag), abort_cnt, e.cnt);
  endtask

  // Queue the expectation for the current inputs, clock once, then score the DUT.
  task automatic cyc(input string tag, input logic [2:0] st, input logic rx,
                     input logic inf, input logic ap, input logic [15:0] cnt);
    exp_t e;
    e.tag = tag; e.st = st; e.rx = rx; e.inf = inf; e.ap = ap; e.cnt = cnt;
    sb_q.push_back(e);
    @(posedge xaui_clk);
    #1;
    e = sb_q.pop_front();
    chk_all(e);
  endtask

  task automatic w_idle();
    data_in = {8{8'h07}};
    ctrl_in = 8'hFF;
  endtask

  task automatic w_data();
    data_in = 64'h0011_2233_4455_6677;
    ctrl_in = 8'h00;
  endtask

  task automatic w_sof0();
    data_in = 64'h0011_2233_4455_66FB;
    ctrl_in = 8'h01;
  endtask

  task automatic w_eof(input int n);
    data_in = 64'h0;
    data_in[8*n +: 8] = 8'hFD;
    ctrl_in = 8'h00;
    ctrl_in[n] = 1'b1;
  endtask

  task automatic w_eof1_sof4();
    data_in = 64'h0;
    data_in[15:8]  = 8'hFD;
    data_in[39:32] = 8'hFB;
    ctrl_in = 8'h12;
  endtask

  // Enable + link + idle stream until ACTIVE; in_frame and abort_cnt are unaffected.
  task automatic bring_up(input bit from_dis, input logic inf, input logic [15:0] cnt);
    sw_rx_en = 1'b1;
    linkup   = 1'b1;
    w_idle();
    if (from_dis) cyc("bu_wl", S_WL, 1'b0, inf, 1'b0, cnt);
    cyc("bu_wi", S_WI, 1'b0, inf, 1'b0, cnt);
    for (int i = 0; i < IDLE_CNT - 1; i++) cyc("bu_count", S_WI, 1'b0, inf, 1'b0, cnt);
    cyc("bu_active", S_AC, 1'b1, inf, 1'b0, cnt);
  endtask

  initial begin
    reset_ = 1'b0; sw_rx_en = 1'b0; xaui_mode = 1'b1; linkup = 1'b0; clr_cnt = 1'b0;
    w_data();
    repeat (2) @(posedge xaui_clk);
    #1;
    chk("rst.state", 16'(ctl_state), 16'(S_DIS));
    chk("rst.rx_en", 16'(rx_en), 16'h0);
    chk("rst.in_frame", 16'(in_frame), 16'h0);
    chk("rst.abort_pulse", 16'(abort_pulse), 16'h0);
    chk("rst.abort_cnt", abort_cnt, 16'h0);

    // Bring-up: DISABLED stays until the first edge after reset release.
    sw_rx_en = 1'b1; linkup = 1'b1; w_idle();
    reset_ = 1'b1;
    #1;
    chk("rel.state", 16'(ctl_state), 16'(S_DIS));
    bring_up(1'b1, 1'b0, 16'h0);

    // Idle break: count restarts after a non-idle word.
    linkup = 1'b0;
    cyc("b_drop", S_WL, 1'b0, 1'b0, 1'b0, 16'h0);
    linkup = 1'b1;
    cyc("b_wi", S_WI, 1'b0, 1'b0, 1'b0, 16'h0);
    repeat (5) cyc("b_idle5", S_WI, 1'b0, 1'b0, 1'b0, 16'h0);
    w_data();
    cyc("b_break", S_WI, 1'b0, 1'b0, 1'b0, 16'h0);
    w_idle();
    repeat (7) cyc("b_recount", S_WI, 1'b0, 1'b0, 1'b0, 16'h0);
    cyc("b_active", S_AC, 1'b1, 1'b0, 1'b0, 16'h0);

    // Graceful disable mid-frame, with a transient re-enable during DRAIN.
    w_sof0();
    cyc("c_sof0", S_AC, 1'b1, 1'b1, 1'b0, 16'h0);
    w_data(); sw_rx_en = 1'b0;
    cyc("c_drain", S_DR, 1'b1, 1'b1, 1'b0, 16'h0);
    for (int k = 1; k <= 9; k++) begin
      sw_rx_en = (k >= 4) && (k <= 6);
      cyc("c_hold", S_DR, 1'b1, 1'b1, 1'b0, 16'h0);
    end
    sw_rx_en = 1'b0; w_eof(2);
    cyc("c_eof", S_DIS, 1'b0, 1'b0, 1'b0, 16'h0);

    // Drain timeout: abort 16 cycles after DRAIN entry.
    bring_up(1'b1, 1'b0, 16'h0);
    w_sof0();
    cyc("d_sof0", S_AC, 1'b1, 1'b1, 1'b0, 16'h0);
    w_data(); sw_rx_en = 1'b0;
    cyc("d_drain", S_DR, 1'b1, 1'b1, 1'b0, 16'h0);
    repeat (DRAIN_TMO - 1) cyc("d_wait", S_DR, 1'b1, 1'b1, 1'b0, 16'h0);
    cyc("d_abort", S_DIS, 1'b0, 1'b1, 1'b1, 16'h1);
    cyc("d_after", S_DIS, 1'b0, 1'b1, 1'b0, 16'h1);

    // EOF on the timeout cycle closes cleanly.
    bring_up(1'b1, 1'b1, 16'h1);
    w_data(); sw_rx_en = 1'b0;
    cyc("e_drain", S_DR, 1'b1, 1'b1, 1'b0, 16'h1);
    repeat (DRAIN_TMO - 1) cyc("e_wait", S_DR, 1'b1, 1'b1, 1'b0, 16'h1);
    w_eof(7);
    cyc("e_eof_tmo", S_DIS, 1'b0, 1'b0, 1'b0, 16'h1);

    // Link loss in DRAIN and counter saturation.
    bring_up(1'b1, 1'b0, 16'h1);
    w_sof0();
    cyc("f_sof0", S_AC, 1'b1, 1'b1, 1'b0, 16'h1);
    force dut.abort_cnt_r = 16'hFFFE;
    #1;
    release dut.abort_cnt_r;
    w_data(); linkup = 1'b0;
    cyc("f_drain", S_DR, 1'b1, 1'b1, 1'b0, 16'hFFFE);
    cyc("f_abort", S_WL, 1'b0, 1'b1, 1'b1, 16'hFFFF);
    bring_up(1'b0, 1'b1, 16'hFFFF);
    w_data(); linkup = 1'b0;
    cyc("f_drain2", S_DR, 1'b1, 1'b1, 1'b0, 16'hFFFF);
    cyc("f_sat", S_WL, 1'b0, 1'b1, 1'b1, 16'hFFFF);

    // EOF in lane 1 plus SOF4 while disabling keeps the frame open.
    bring_up(1'b0, 1'b1, 16'hFFFF);
    w_eof(0);
    cyc("g_eof0", S_AC, 1'b1, 1'b0, 1'b0, 16'hFFFF);
    w_eof1_sof4(); sw_rx_en = 1'b0;
    cyc("g_eof_sof4", S_DR, 1'b1, 1'b1, 1'b0, 16'hFFFF);
    w_eof(3);
    cyc("g_exit", S_DIS, 1'b0, 1'b0, 1'b0, 16'hFFFF);

    // 1G mode ignores linkup.
    xaui_mode = 1'b0; linkup = 1'b0; sw_rx_en = 1'b1; w_idle();
    cyc("g1_wl", S_WL, 1'b0, 1'b0, 1'b0, 16'hFFFF);
    cyc("g1_wi", S_WI, 1'b0, 1'b0, 1'b0, 16'hFFFF);
    repeat (IDLE_CNT - 1) cyc("g1_count", S_WI, 1'b0, 1'b0, 1'b0, 16'hFFFF);
    cyc("g1_active", S_AC, 1'b1, 1'b0, 1'b0, 16'hFFFF);

    // Asynchronous reset mid-frame.
    w_sof0();
    cyc("h_sof0", S_AC, 1'b1, 1'b1, 1'b0, 16'hFFFF);
    w_data();
    #2;
    reset_ = 1'b0;
    #1;
    chk("h_rst.state", 16'(ctl_state), 16'(S_DIS));
    chk("h_rst.rx_en", 16'(rx_en), 16'h0);
    chk("h_rst.in_frame", 16'(in_frame), 16'h0);
    chk("h_rst.abort_pulse", 16'(abort_pulse), 16'h0);
    chk("h_rst.abort_cnt", abort_cnt, 16'h0);
    @(negedge xaui_clk);
    reset_ = 1'b1; xaui_mode = 1'b1;
    #1;
    chk("h_rel.state", 16'(ctl_state), 16'(S_DIS));

    // clr_cnt wins over a simultaneous abort.
    bring_up(1'b1, 1'b0, 16'h0);
    w_sof0();
    cyc("i_sof0", S_AC, 1'b1, 1'b1, 1'b0, 16'h0);
    w_data(); linkup = 1'b0;
    cyc("i_drain", S_DR, 1'b1, 1'b1, 1'b0, 16'h0);
    clr_cnt = 1'b1;
    cyc("i_clr_abort", S_WL, 1'b0, 1'b1, 1'b1, 16'h0);
    clr_cnt = 1'b0;
    cyc("i_after", S_WL, 1'b0, 1'b1, 1'b0, 16'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/rx_path_ctrl.md
RX_PATH_CTRL -- requirements
Module: rx_path_ctrl

Interface
REQ-001 SHALL have parameter IDLE_CNT, default 8, number of consecutive idle words required before enabling receive.
REQ-002 SHALL have parameter DRAIN_TMO, default 2048, maximum DRAIN cycles allowed before a frame is aborted.
REQ-003 SHALL have port xaui_clk, input, 1, the single clock; all logic on its rising edge.
REQ-004 SHALL have port reset_, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port sw_rx_en, input, 1, software receive enable (register bit).
REQ-006 SHALL have port xaui_mode, input, 1; 1 = 10G XGMII, 0 = 1G, where linkup is ignored and treated as 1.
REQ-007 SHALL have port linkup, input, 1, link-good indication from the link FSM.
REQ-008 SHALL have port data_in, input, 64, XGMII data, lane n = bits [8n+7:8n].
REQ-009 SHALL have port ctrl_in, input, 8, XGMII control, bit n = lane n.
REQ-010 SHALL have port clr_cnt, input, 1, synchronous clear pulse for abort_cnt.
REQ-011 SHALL have port rx_en, output, 1, gated receive-path enable (fmac_rxd_en).
REQ-012 SHALL have port ctl_state, output, 3, current state encoding.
REQ-013 SHALL have port in_frame, output, 1, frame currently open.
REQ-014 SHALL have port abort_pulse, output, 1, one-cycle pulse on a drain timeout or a link loss during drain.
REQ-015 SHALL have port abort_cnt, output, 16, saturating count of aborts.

Function
REQ-016 SHALL decode each word as follows.
- SOF0: lane0 = FB with ctrl[0] set.
- SOF4: lane4 = FB with ctrl[4] set.
- EOF: any lane n = FD with ctrl[n] set.
- IDLE: ctrl_in = FF and every byte = 07; a 9C sequence is not idle.
REQ-017 SHALL update in_frame each cycle with this priority: SOF4 gives 1, else EOF gives 0, else SOF0 gives 1, else hold.
REQ-018 SHALL therefore give in_frame = 1 when EOF in lanes 0-3 and SOF4 occur in the same word.
REQ-019 SHALL define link_ok = linkup | !xaui_mode.
REQ-020 SHALL implement states DISABLED=0, WAIT_LINK=1, WAIT_IDLE=2, ACTIVE=3, DRAIN=4; codes 5-7 go to DISABLED on the next cycle.
REQ-021 SHALL transition from DISABLED to WAIT_LINK when sw_rx_en = 1.
REQ-022 SHALL transition from WAIT_LINK:
- to DISABLED if !sw_rx_en;
- else to WAIT_IDLE if link_ok.
REQ-023 SHALL transition from WAIT_IDLE:
- to DISABLED if !sw_rx_en;
- else to WAIT_LINK if !link_ok;
- else to ACTIVE on the IDLE_CNT-th consecutive IDLE word.
REQ-024 SHALL reset the idle counter to 0 on any non-IDLE word and on WAIT_IDLE entry; the counter SHALL saturate, not wrap.
REQ-025 SHALL transition from ACTIVE, when !sw_rx_en or !link_ok:
- to DRAIN if in_frame (its next value) = 1;
- else to DISABLED if !sw_rx_en, otherwise to WAIT_LINK.
REQ-026 SHALL, in DRAIN, leave the drain counter at 0 on entry and increment it each cycle.
REQ-027 SHALL, in DRAIN, exit without abort on EOF.
REQ-028 SHALL, in DRAIN, abort when !link_ok or the counter reaches DRAIN_TMO-1 without EOF.
REQ-029 SHALL, on DRAIN exit, go to DISABLED if !sw_rx_en, else to WAIT_LINK.
REQ-030 SHALL give EOF priority over timeout when both occur in the same cycle, with no abort.
REQ-031 SHALL stay in DRAIN if sw_rx_en reasserts during DRAIN; the DRAIN exit decision uses sw_rx_en at exit.
REQ-032 SHALL register rx_en = 1 exactly when the state is ACTIVE or DRAIN, on the same edge as the state register.
REQ-033 SHALL have one-cycle latency from the sampled input condition to the new state and rx_en.
REQ-034 SHALL register abort_pulse high for one cycle on the edge DRAIN exits by abort.
REQ-035 SHALL increment abort_cnt by 1 on each abort, holding at FFFF.
REQ-036 SHALL clear abort_cnt on clr_cnt; clr_cnt wins over a simultaneous abort, giving 0.

Reset
REQ-037 SHALL, while reset_ = 0, asynchronously force:
- state = DISABLED and ctl_state = 0;
- rx_en = 0, in_frame = 0, abort_pulse = 0;
- abort_cnt = 0, idle counter = 0, drain counter = 0.
REQ-038 SHALL force rx_en low immediately on reset mid-frame, with no drain and no abort count.
REQ-039 SHALL leave DISABLED no earlier than the first rising edge after reset_ deasserts.

Verification
REQ-040 SHALL cover bring-up: xaui_mode=1, sw_rx_en=1, linkup=1, 8 idle words -> ctl_state 1, 2, then 3, with rx_en=1 one cycle after the 8th idle.
REQ-041 SHALL cover idle break: a non-idle word (ctrl=00) after 5 idles -> count restarts, and ACTIVE only after 8 further consecutive idles.
REQ-042 SHALL cover graceful disable: sw_rx_en dropped mid-frame after SOF0 -> DRAIN, then FD with ctrl[2] 10 cycles later -> DISABLED, rx_en=0, abort_cnt unchanged.
REQ-043 SHALL cover drain timeout: DRAIN_TMO=16, no EOF -> abort_pulse one cycle, 16 cycles after DRAIN entry, abort_cnt=1, state DISABLED.
REQ-044 SHALL cover link loss plus saturation: linkup=0 in DRAIN -> abort, WAIT_LINK; abort_cnt preloaded by 65535 aborts stays FFFF; clr_cnt -> 0.
REQ-045 SHALL cover the EOF/SOF4 word (lane1 FD, lane4 FB) while disabling -> in_frame=1, DRAIN entered; xaui_mode=0 with linkup=0 -> WAIT_LINK exits to WAIT_IDLE.
